// File: rtl/serial_mem_responder.sv
// Bit-serial memory target: takes an LSB-first address (plus write data), then writes
// to or reads from a small local byte memory, with burst and bus back-pressure support.
module serial_mem_responder #(
  parameter int MemN      = 4,
  parameter int N         = 8,
  parameter int ADN       = 12,
  parameter int DelayN    = 2,
  parameter int BURST_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       validIn,
  input  logic       wren,
  input  logic       Address,
  input  logic       DataIn,
  input  logic       BurstEn,
  input  logic       BusAvailable,
  output logic       ready,
  output logic       validOut,
  output logic       hold,
  output logic       DataOut,
  output logic [3:0] state_out
);

  // Handshake: validIn qualifies one Address/DataIn bit per cycle and cannot be refused;
  // BusAvailable is the ready for read bits, a low cycle freezes the stream for one cycle.
  localparam int DEPTH = 1 << MemN;
  localparam int CW    = $clog2(((ADN > N) ? ADN : N) + 1);
  localparam int BW    = $clog2(BURST_LEN + 1);
  localparam int DW    = $clog2(DelayN + 2);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ADDR  = 4'd1,
    S_WDATA = 4'd2,
    S_RWAIT = 4'd3,
    S_RDATA = 4'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [MemN-1:0] r_addr;
  logic [MemN-1:0] w_addr_upd;
  logic [MemN-1:0] w_addr_inc;
  logic [N-1:0]    r_mem [DEPTH];
  logic [N-1:0]    r_shift;
  logic [N-1:0]    w_wbyte;
  logic [CW-1:0]   r_cnt;
  logic [BW-1:0]   r_beat;
  logic [DW-1:0]   r_delay;
  logic            r_wr;
  logic            r_burst;
  logic            r_ready;
  logic            r_valid;
  logic            r_hold;
  logic            r_dout;
  logic            w_ready_nxt;
  logic            w_valid_nxt;
  logic            w_hold_nxt;
  logic            w_dout_nxt;
  logic            w_last_addr;
  logic            w_last_bit;
  logic            w_more;

  assign w_last_addr = validIn && (r_cnt == CW'(ADN - 1));
  assign w_last_bit  = (r_cnt == CW'(N - 1));
  assign w_more      = r_burst && ((r_beat + BW'(1)) < BW'(BURST_LEN));
  assign w_addr_inc  = r_addr + MemN'(1);
  assign w_wbyte     = {DataIn, r_shift[N-1:1]};

  // Address bits at or above MemN are consumed but never stored.
  always_comb begin
    w_addr_upd = r_addr;
    for (int i = 0; i < MemN; i++) begin
      if (r_cnt == CW'(i)) w_addr_upd[i] = Address;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (validIn) w_state_nxt = S_ADDR;
      S_ADDR:  if (w_last_addr) begin
                 if (r_wr)             w_state_nxt = S_WDATA;
                 else if (DelayN == 0) w_state_nxt = S_RDATA;
                 else                  w_state_nxt = S_RWAIT;
               end
      S_WDATA: if (validIn && w_last_bit && !w_more) w_state_nxt = S_IDLE;
      S_RWAIT: if (r_delay <= DW'(1)) w_state_nxt = S_RDATA;
      S_RDATA: if (BusAvailable && w_last_bit && !w_more) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; ready trails the state by one cycle.
  always_comb begin
    w_ready_nxt = (r_state == S_IDLE);
    w_valid_nxt = (r_state == S_RDATA) && BusAvailable;
    w_hold_nxt  = (r_state == S_RDATA) && !BusAvailable;
    w_dout_nxt  = w_valid_nxt && r_shift[0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_addr  <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_beat  <= '0;
      r_delay <= '0;
      r_wr    <= 1'b0;
      r_burst <= 1'b0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_hold  <= 1'b0;
      r_dout  <= 1'b0;
    end else begin
      r_ready <= w_ready_nxt;
      r_valid <= w_valid_nxt;
      r_hold  <= w_hold_nxt;
      r_dout  <= w_dout_nxt;
      case (r_state)
        S_IDLE: if (validIn) begin
          r_addr  <= {{(MemN-1){1'b0}}, Address};
          r_wr    <= wren;
          r_burst <= BurstEn;
          r_cnt   <= CW'(1);
          r_beat  <= '0;
        end
        S_ADDR: if (validIn) begin
          r_addr <= w_addr_upd;
          if (w_last_addr) begin
            r_cnt   <= '0;
            r_delay <= DW'(DelayN);
            if (!r_wr && DelayN == 0) r_shift <= r_mem[w_addr_upd];
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WDATA: if (validIn) begin
          if (w_last_bit) begin
            r_mem[r_addr] <= w_wbyte;
            r_cnt         <= '0;
            r_beat        <= r_beat + BW'(1);
            r_shift       <= '0;
            if (w_more) r_addr <= w_addr_inc;
          end else begin
            r_shift <= w_wbyte;
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        S_RWAIT: begin
          if (r_delay <= DW'(1)) begin
            r_delay <= '0;
            r_shift <= r_mem[r_addr];
          end else begin
            r_delay <= r_delay - DW'(1);
          end
        end
        S_RDATA: if (BusAvailable) begin
          if (w_last_bit) begin
            r_cnt  <= '0;
            r_beat <= r_beat + BW'(1);
            if (w_more) begin
              r_addr  <= w_addr_inc;
              r_shift <= r_mem[w_addr_inc];
            end
          end else begin
            r_shift <= r_shift >> 1;
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ready     = r_ready;
  assign validOut  = r_valid;
  assign hold      = r_hold;
  assign DataOut   = r_dout;
  assign state_out = r_state;

endmodule
